stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input conditioning, tick divider and RUN/PAUSE/ADJ sequencing.
// Optional blinking of the selected field in adjust mode is enabled by STOPWATCH_BLINK_EN.
module stopwatch_ctrl #(
   parameter int TICK_DIV  = 100000000,
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_pause,
   input  logic btn_reset,
   input  logic sw_adjust,
   input  logic sw_select,
   output logic cnt_en,
   output logic cnt_clear,
   output logic adj_mode,
   output logic adj_sel,
   output logic paused,
   output logic blink
);

   localparam int DW = $clog2(TICK_DIV);
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2 - 1);
   localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_ADJ} state_t;

   // Bit order of all conditioned-input vectors: 0 pause, 1 clear, 2 adjust, 3 select.
   logic [3:0]         raw;
   logic [3:0]         sync1_q, sync2_q;
   logic [3:0]         lvl_q, lvl_d;
   logic [3:0][CW-1:0] dbc_q, dbc_d;
   state_t             state_q, state_d;
   logic [DW-1:0]      div_q, div_d;
   logic               paused_q, paused_d;
   logic               cnt_en_q, cnt_en_d;
   logic               cnt_clear_q, cnt_clear_d;
   logic               adj_mode_q, adj_mode_d;
   logic               pause_evt, reset_evt, adj_rise, adj_fall;
   logic               run_tick, adj_tick, adj_edge;

   assign raw = {sw_select, sw_adjust, btn_reset, btn_pause};

   always_comb begin
      lvl_d = lvl_q;
      dbc_d = dbc_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != lvl_q[i]) begin
            if (dbc_q[i] == DB_LAST) begin
               lvl_d[i] = sync2_q[i];
               dbc_d[i] = '0;
            end else begin
               dbc_d[i] = dbc_q[i] + CW'(1);
            end
         end else begin
            dbc_d[i] = '0;
         end
      end
   end

   assign pause_evt = lvl_d[0] & ~lvl_q[0];
   assign reset_evt = lvl_d[1] & ~lvl_q[1];
   assign adj_rise  = lvl_d[2] & ~lvl_q[2];
   assign adj_fall  = ~lvl_d[2] & lvl_q[2];
   assign run_tick  = (div_q == DIV_LAST);
   assign adj_tick  = run_tick | (div_q == DIV_HALF);

   always_comb begin
      paused_d = paused_q ^ pause_evt;
      state_d  = state_q;
      case (state_q)
         ST_RUN: begin
            if (adj_rise)       state_d = ST_ADJ;
            else if (pause_evt) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (adj_rise)       state_d = ST_ADJ;
            else if (pause_evt) state_d = ST_RUN;
         end
         ST_ADJ: begin
            // Leaving adjust lands in whichever state matches the updated pause flag.
            if (adj_fall) state_d = paused_d ? ST_PAUSE : ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      cnt_en_d    = ~reset_evt & (((state_q == ST_RUN) & run_tick) |
                                  ((state_q == ST_ADJ) & ~paused_q & adj_tick));
      cnt_clear_d = reset_evt;
      adj_mode_d  = (state_d == ST_ADJ);
      adj_edge    = (state_d == ST_ADJ) != (state_q == ST_ADJ);
      if (reset_evt || adj_edge || run_tick) div_d = '0;
      else                                   div_d = div_q + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         lvl_q       <= '0;
         dbc_q       <= '0;
         state_q     <= ST_RUN;
         div_q       <= '0;
         paused_q    <= 1'b0;
         cnt_en_q    <= 1'b0;
         cnt_clear_q <= 1'b0;
         adj_mode_q  <= 1'b0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         lvl_q       <= lvl_d;
         dbc_q       <= dbc_d;
         state_q     <= state_d;
         div_q       <= div_d;
         paused_q    <= paused_d;
         cnt_en_q    <= cnt_en_d;
         cnt_clear_q <= cnt_clear_d;
         adj_mode_q  <= adj_mode_d;
      end
   end

   assign cnt_en    = cnt_en_q;
   assign cnt_clear = cnt_clear_q;
   assign adj_mode  = adj_mode_q;
   assign adj_sel   = lvl_q[3];
   assign paused    = paused_q;

`ifdef STOPWATCH_BLINK_EN
   localparam int BW = $clog2(TICK_DIV / 4);
   localparam logic [BW-1:0] BLINK_LAST = BW'(TICK_DIV / 4 - 1);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_q, blink_d;

   // Restarts visible with a fresh phase on every ADJ entry; solid outside ADJ.
   always_comb begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
      if (state_d == ST_ADJ && state_q == ST_ADJ) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_d     = blink_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign blink = blink_q;
`else
   assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random input segments,
// every cycle compared against a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

   localparam int TD = 8;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_pause = 1'b0, btn_reset = 1'b0, sw_adjust = 1'b0, sw_select = 1'b0;
   logic cnt_en, cnt_clear, adj_mode, adj_sel, paused, blink;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_pause (btn_pause),
      .btn_reset (btn_reset),
      .sw_adjust (sw_adjust),
      .sw_select (sw_select),
      .cnt_en    (cnt_en),
      .cnt_clear (cnt_clear),
      .adj_mode  (adj_mode),
      .adj_sel   (adj_sel),
      .paused    (paused),
      .blink     (blink)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: raw inputs delayed two samples, then accepted after DB
   // consecutive disagreeing samples. Being "in adjust" is simply the accepted
   // adjust level; the pause flag is a toggle of accepted pause presses.
   logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
   int   m_run[4] = '{0, 0, 0, 0};
   int   m_div = 0;
   int   m_age = 0;
   logic m_paused = 1'b0, m_en = 1'b0, m_clr = 1'b0, m_blink = 1'b1;

   int   en_cnt = 0, clr_cnt = 0, blink_chg = 0;
   int   last_clr = -1, en_after_clr = -1;
   logic prev_blink = 1'b1;

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic model_step();
      logic [3:0] raw, old_s2, old_lvl;
      logic pev, rev, was_adj, t_run, t_adj;
      raw = {sw_select, sw_adjust, btn_reset, btn_pause};
      if (!reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_div = 0; m_age = 0; m_paused = 1'b0;
         m_en = 1'b0; m_clr = 1'b0; m_blink = 1'b1;
         return;
      end
      old_s2  = m_s2;
      old_lvl = m_lvl;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int i = 0; i < 4; i++) begin
         if (old_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_lvl[i] = old_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      pev     = m_lvl[0] & ~old_lvl[0];
      rev     = m_lvl[1] & ~old_lvl[1];
      was_adj = old_lvl[2];
      t_run   = (m_div == TD - 1);
      t_adj   = t_run || (m_div == TD / 2 - 1);
      m_en    = !rev && !m_paused && (was_adj ? t_adj : t_run);
      m_clr   = rev;
      m_paused = m_paused ^ pev;
      if (rev || (m_lvl[2] != was_adj)) m_div = 0;
      else                              m_div = (m_div + 1) % TD;
`ifdef STOPWATCH_BLINK_EN
      if (m_lvl[2]) begin
         if (!was_adj) m_age = 0;
         else          m_age++;
         m_blink = ((m_age / (TD / 4)) % 2) == 0;
      end else begin
         m_blink = 1'b1;
      end
`else
      m_blink = 1'b1;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
      check("cnt_en",    cnt_en,    m_en);
      check("cnt_clear", cnt_clear, m_clr);
      check("adj_mode",  adj_mode,  m_lvl[2]);
      check("adj_sel",   adj_sel,   m_lvl[3]);
      check("paused",    paused,    m_paused);
      check("blink",     blink,     m_blink);
      if (cnt_en) en_cnt++;
      if (cnt_clear) begin
         clr_cnt++;
         last_clr = cyc;
      end
      if (cnt_en && last_clr >= 0 && en_after_clr < 0) en_after_clr = cyc - last_clr;
      if (blink !== prev_blink) blink_chg++;
      prev_blink = blink;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and free run
      reset = 1'b0;
      run(3);
      check("rst_cnt_en", cnt_en, 1'b0);
      check("rst_paused", paused, 1'b0);
      check("rst_blink",  blink,  1'b1);
      reset = 1'b1;
      en_cnt = 0;
      run(24);
      check_int("run_pulses", en_cnt, 3);

      // Long pause press, then verify silence
      btn_pause = 1'b1; run(12);
      btn_pause = 1'b0; run(4);
      check("pause_on", paused, 1'b1);
      en_cnt = 0; run(20);
      check_int("pause_no_en", en_cnt, 0);

      // Second press resumes
      btn_pause = 1'b1; run(8);
      btn_pause = 1'b0; run(8);
      check("pause_off", paused, 1'b0);
      en_cnt = 0; run(24);
      check_int("resume_pulses", en_cnt, 3);

      // Short glitch is rejected
      btn_pause = 1'b1; run(3);
      btn_pause = 1'b0; run(10);
      check("glitch_paused", paused, 1'b0);

      // Adjust mode on seconds field
      sw_select = 1'b1; sw_adjust = 1'b1; run(8);
      check("adj_on", adj_mode, 1'b1);
      check("adj_sel_on", adj_sel, 1'b1);
      en_cnt = 0; blink_chg = 0; run(16);
      check_int("adj_pulses", en_cnt, 4);
`ifdef STOPWATCH_BLINK_EN
      check_int("adj_blink_toggles", blink_chg, 8);
`else
      check_int("adj_blink_toggles", blink_chg, 0);
`endif
      sw_adjust = 1'b0; run(8);
      check("adj_off", adj_mode, 1'b0);
      check("adj_off_blink", blink, 1'b1);

      // Clear press landing while the divider sits at 5
      for (int i = 0; i < TD && m_div != 0; i++) step();
      clr_cnt = 0; last_clr = -1; en_after_clr = -1;
      btn_reset = 1'b1; run(10);
      btn_reset = 1'b0; run(20);
      check_int("clear_pulses", clr_cnt, 1);
      check_int("clear_to_en", en_after_clr, 8);

      // Reset while in ADJ with adjust frozen
      btn_pause = 1'b1; run(8);
      btn_pause = 1'b0; run(8);
      sw_adjust = 1'b1; run(10);
      check("frozen_adj", adj_mode, 1'b1);
      check("frozen_paused", paused, 1'b1);
      reset = 1'b0; sw_adjust = 1'b0; sw_select = 1'b0;
      step();
      check("mid_rst_cnt_en", cnt_en, 1'b0);
      check("mid_rst_clear", cnt_clear, 1'b0);
      check("mid_rst_adj", adj_mode, 1'b0);
      check("mid_rst_paused", paused, 1'b0);
      check("mid_rst_blink", blink, 1'b1);
      run(2);
      reset = 1'b1;

      // Random segments
      for (int s = 0; s < 60; s++) begin
         btn_pause = 1'($urandom_range(0, 1));
         btn_reset = ($urandom_range(0, 3) == 0);
         sw_adjust = 1'($urandom_range(0, 1));
         sw_select = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 19) != 0);
         run($urandom_range(1, 12));
      end
      reset = 1'b1;
      run(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
